// File: rtl/hermes_link_buffer.sv
// Hermes link buffer: fixed-latency forward pipeline into a circular FIFO,
// with credit flow control upstream and valid/credit handshake downstream.
module hermes_link_buffer #(
    parameter int FLIT_SIZE = 32,
    parameter int STAGES    = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic                 eop_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 tx_o,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic [CNT_W-1:0]     pkt_cnt_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = $clog2(DEPTH + 1);

    typedef logic [FLIT_SIZE:0] flit_t;  // {eop, data}

    if (FLIT_SIZE < 20) begin : g_bad_flit
        $error("hermes_link_buffer: FLIT_SIZE must be >= 20");
    end
    if (STAGES < 0 || STAGES > 4) begin : g_bad_stages
        $error("hermes_link_buffer: STAGES must be in 0..4");
    end
    if (DEPTH < STAGES + 2) begin : g_bad_depth
        $error("hermes_link_buffer: DEPTH must be >= STAGES+2");
    end

    logic          accept, pop, wr_vld;
    flit_t         wr_flit, head;
    flit_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [RW-1:0] count, reserved, reserved_next;

    assign accept = rx_i & credit_o;
    assign pop    = tx_o & credit_i;

    // Forward pipeline never stalls: room was reserved at acceptance time.
    if (STAGES == 0) begin : g_nopipe
        assign wr_vld  = accept;
        assign wr_flit = {eop_i, data_i};
    end else begin : g_pipe
        logic [STAGES-1:0] vld_pipe;
        flit_t             flit_pipe [STAGES];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= accept;
                for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            flit_pipe[0] <= {eop_i, data_i};
            for (int i = 1; i < STAGES; i++) flit_pipe[i] <= flit_pipe[i-1];
        end

        assign wr_vld  = vld_pipe[STAGES-1];
        assign wr_flit = flit_pipe[STAGES-1];
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            count <= count + RW'(wr_vld) - RW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_vld) mem[wr_ptr] <= wr_flit;
    end

    assign head           = mem[rd_ptr];
    assign tx_o           = (count != '0);
    assign {eop_o, data_o} = tx_o ? head : '0;

    // reserved covers pipeline plus FIFO, so credit can never overcommit the FIFO.
    assign reserved_next = reserved + RW'(accept) - RW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reserved <= '0;
            credit_o <= 1'b0;
        end else begin
            reserved <= reserved_next;
            credit_o <= (reserved_next < RW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_o <= '0;
        end else if (pop && eop_o && (pkt_cnt_o != '1)) begin
            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(wr_vld && count == RW'(DEPTH)));
    end

endmodule
